// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine: shared storage with join modes,
// fall-through heads, fill levels, sticky error flags and level interrupts.
module pio_fifo_pair #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int LW = $clog2(2 * DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       join_mode,
    input  logic             flush,

    input  logic             tx_push,
    input  logic [WIDTH-1:0] tx_din,
    output logic             tx_full,
    output logic [LW-1:0]    tx_level,
    input  logic             tx_pull,
    output logic [WIDTH-1:0] tx_dout,
    output logic             tx_empty,

    input  logic             rx_push,
    input  logic [WIDTH-1:0] rx_din,
    output logic             rx_full,
    output logic [LW-1:0]    rx_level,
    input  logic             rx_pull,
    output logic [WIDTH-1:0] rx_dout,
    output logic             rx_empty,

    input  logic [LW-1:0]    tx_thresh,
    input  logic [LW-1:0]    rx_thresh,
    output logic [3:0]       flags,
    input  logic [3:0]       flag_clr,
    output logic             irq_tx,
    output logic             irq_rx
);

    localparam int PW = $clog2(2 * DEPTH);
    localparam int ENTRIES = 2 * DEPTH;

    localparam logic [1:0] JOIN_NONE = 2'b00;
    localparam logic [1:0] JOIN_TX   = 2'b01;
    localparam logic [1:0] JOIN_RX   = 2'b10;

    localparam logic [LW-1:0] CAP_NORM = LW'(DEPTH);
    localparam logic [LW-1:0] CAP_JOIN = LW'(2 * DEPTH);
    localparam logic [PW-1:0] RX_BASE_NORM = PW'(DEPTH);

    logic [1:0]       join_q, join_d;
    logic [PW-1:0]    tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [PW-1:0]    rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [LW-1:0]    tx_level_q, tx_level_d;
    logic [LW-1:0]    rx_level_q, rx_level_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] mem_d [ENTRIES];

    logic             join_chg, clear;
    logic             tx_en, rx_en;
    logic [LW-1:0]    tx_cap, rx_cap;
    logic [PW-1:0]    rx_base;
    logic             tx_push_ok, tx_pull_ok, rx_push_ok, rx_pull_ok;
    logic [3:0]       flag_set;

    // Pointers are offsets inside the owning partition and wrap at its capacity.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [LW-1:0] cap);
        logic [PW-1:0] r;
        if ({1'b0, p} == cap - LW'(1)) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] level_next(input logic [LW-1:0] lvl, input logic push_ok,
                                                 input logic pull_ok);
        logic [LW-1:0] r;
        case ({push_ok, pull_ok})
            2'b10:   r = lvl + LW'(1);
            2'b01:   r = lvl - LW'(1);
            default: r = lvl;
        endcase
        return r;
    endfunction

    always_comb begin
        join_chg = (join_mode != join_q);
        clear    = join_chg | flush;

        tx_en   = (join_q != JOIN_RX);
        rx_en   = (join_q != JOIN_TX);
        tx_cap  = (join_q == JOIN_TX) ? CAP_JOIN : CAP_NORM;
        rx_cap  = (join_q == JOIN_RX) ? CAP_JOIN : CAP_NORM;
        rx_base = (join_q == JOIN_RX) ? '0 : RX_BASE_NORM;

        tx_pull_ok = !clear && tx_pull && tx_en && (tx_level_q != '0);
        tx_push_ok = !clear && tx_push && tx_en && ((tx_level_q != tx_cap) || tx_pull_ok);
        rx_pull_ok = !clear && rx_pull && rx_en && (rx_level_q != '0);
        rx_push_ok = !clear && rx_push && rx_en && ((rx_level_q != rx_cap) || rx_pull_ok);

        // Operations swallowed by a flush or mode change are not errors.
        flag_set[0] = !clear && tx_push && !tx_push_ok;
        flag_set[1] = !clear && tx_pull && !tx_pull_ok;
        flag_set[2] = !clear && rx_push && !rx_push_ok;
        flag_set[3] = !clear && rx_pull && !rx_pull_ok;
        flags_d     = (flags_q & ~flag_clr) | flag_set;

        join_d = join_mode;

        if (clear) begin
            tx_rd_d    = '0;
            tx_wr_d    = '0;
            rx_rd_d    = '0;
            rx_wr_d    = '0;
            tx_level_d = '0;
            rx_level_d = '0;
        end else begin
            tx_rd_d    = tx_pull_ok ? ptr_inc(tx_rd_q, tx_cap) : tx_rd_q;
            tx_wr_d    = tx_push_ok ? ptr_inc(tx_wr_q, tx_cap) : tx_wr_q;
            rx_rd_d    = rx_pull_ok ? ptr_inc(rx_rd_q, rx_cap) : rx_rd_q;
            rx_wr_d    = rx_push_ok ? ptr_inc(rx_wr_q, rx_cap) : rx_wr_q;
            tx_level_d = level_next(tx_level_q, tx_push_ok, tx_pull_ok);
            rx_level_d = level_next(rx_level_q, rx_push_ok, rx_pull_ok);
        end

        mem_d = mem_q;
        if (tx_push_ok) begin
            mem_d[tx_wr_q] = tx_din;
        end
        if (rx_push_ok) begin
            mem_d[rx_base + rx_wr_q] = rx_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            join_q     <= JOIN_NONE;
            tx_rd_q    <= '0;
            tx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_wr_q    <= '0;
            tx_level_q <= '0;
            rx_level_q <= '0;
            flags_q    <= '0;
        end else begin
            join_q     <= join_d;
            tx_rd_q    <= tx_rd_d;
            tx_wr_q    <= tx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_wr_q    <= rx_wr_d;
            tx_level_q <= tx_level_d;
            rx_level_q <= rx_level_d;
            flags_q    <= flags_d;
        end
    end

    // Storage is never scrubbed; empty FIFOs mask their head to zero instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx_level = tx_en ? tx_level_q : '0;
    assign rx_level = rx_en ? rx_level_q : '0;
    assign tx_empty = !tx_en || (tx_level_q == '0);
    assign rx_empty = !rx_en || (rx_level_q == '0);
    assign tx_full  = !tx_en || (tx_level_q == tx_cap);
    assign rx_full  = !rx_en || (rx_level_q == rx_cap);
    assign tx_dout  = tx_empty ? '0 : mem_q[tx_rd_q];
    assign rx_dout  = rx_empty ? '0 : mem_q[rx_base + rx_rd_q];

    assign flags  = flags_q;
    assign irq_tx = tx_en && (tx_level_q <= tx_thresh);
    assign irq_rx = rx_en && (rx_thresh != '0) && (rx_level_q >= rx_thresh);

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed bench for pio_fifo_pair (WIDTH=32, DEPTH=4): inputs change on the
// falling edge, outputs are checked on the following falling edge.
module tb_pio_fifo_pair;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(2 * DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       join_mode;
    logic             flush;
    logic             tx_push, tx_pull, rx_push, rx_pull;
    logic [WIDTH-1:0] tx_din, rx_din;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0]    tx_level, rx_level, tx_thresh, rx_thresh;
    logic [WIDTH-1:0] tx_dout, rx_dout;
    logic [3:0]       flags, flag_clr;
    logic             irq_tx, irq_rx;

    int n_cmp = 0;
    int n_err = 0;

    pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .join_mode(join_mode), .flush(flush),
        .tx_push(tx_push), .tx_din(tx_din), .tx_full(tx_full), .tx_level(tx_level),
        .tx_pull(tx_pull), .tx_dout(tx_dout), .tx_empty(tx_empty),
        .rx_push(rx_push), .rx_din(rx_din), .rx_full(rx_full), .rx_level(rx_level),
        .rx_pull(rx_pull), .rx_dout(rx_dout), .rx_empty(rx_empty),
        .tx_thresh(tx_thresh), .rx_thresh(rx_thresh), .flags(flags),
        .flag_clr(flag_clr), .irq_tx(irq_tx), .irq_rx(irq_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then drop all single-cycle strobes.
    task automatic step();
        @(negedge clk);
        tx_push  = 1'b0;
        tx_pull  = 1'b0;
        rx_push  = 1'b0;
        rx_pull  = 1'b0;
        flush    = 1'b0;
        flag_clr = 4'h0;
    endtask

    logic [31:0] exp_tx [4];
    logic [31:0] exp_rx [4];
    logic [31:0] q [$];
    logic [31:0] nxt;

    initial begin
        reset = 1'b0; join_mode = 2'b00; flush = 1'b0;
        tx_push = 1'b0; tx_pull = 1'b0; rx_push = 1'b0; rx_pull = 1'b0;
        tx_din = '0; rx_din = '0; flag_clr = 4'h0;
        tx_thresh = 4'd1; rx_thresh = 4'd3;
        step();
        step();
        chk("rst_tx_level", 32'(tx_level), 32'd0);
        chk("rst_tx_empty", 32'(tx_empty), 32'd1);
        chk("rst_tx_full", 32'(tx_full), 32'd0);
        chk("rst_tx_dout", tx_dout, 32'h0);
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("rst_rx_full", 32'(rx_full), 32'd0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_irq_tx", 32'(irq_tx), 32'd1);
        chk("rst_irq_rx", 32'(irq_rx), 32'd0);
        reset = 1'b1;
        step();

        // Fill TX to capacity.
        tx_push = 1'b1; tx_din = 32'h11; step();
        chk("tx_push1_level", 32'(tx_level), 32'd1);
        chk("tx_push1_dout", tx_dout, 32'h11);
        chk("tx_push1_irq", 32'(irq_tx), 32'd1);
        tx_push = 1'b1; tx_din = 32'h22; step();
        tx_push = 1'b1; tx_din = 32'h33; step();
        tx_push = 1'b1; tx_din = 32'h44; step();
        chk("tx_fill_level", 32'(tx_level), 32'd4);
        chk("tx_fill_full", 32'(tx_full), 32'd1);
        chk("tx_fill_irq", 32'(irq_tx), 32'd0);
        chk("tx_fill_dout", tx_dout, 32'h11);

        tx_push = 1'b1; tx_din = 32'h55; step();
        chk("tx_ovf_level", 32'(tx_level), 32'd4);
        chk("tx_ovf_flag", 32'(flags), 32'h1);

        // Clear and a new overflow in the same cycle: set wins.
        tx_push = 1'b1; tx_din = 32'h56; flag_clr = 4'b0001; step();
        chk("clr_vs_set", 32'(flags), 32'h1);
        flag_clr = 4'b0001; step();
        chk("clr_alone", 32'(flags), 32'h0);

        // Full FIFO with simultaneous push and pull.
        chk("full_pp_head", tx_dout, 32'h11);
        tx_push = 1'b1; tx_din = 32'hAA; tx_pull = 1'b1; step();
        chk("full_pp_level", 32'(tx_level), 32'd4);
        chk("full_pp_dout", tx_dout, 32'h22);
        chk("full_pp_flags", 32'(flags), 32'h0);
        exp_tx = '{32'h22, 32'h33, 32'h44, 32'hAA};
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain_head", tx_dout, exp_tx[i]);
            tx_pull = 1'b1; step();
            chk("tx_drain_level", 32'(tx_level), 32'(3 - i));
        end
        chk("tx_drained_empty", 32'(tx_empty), 32'd1);
        chk("tx_drained_dout", tx_dout, 32'h0);
        chk("tx_drained_irq", 32'(irq_tx), 32'd1);

        // Push and pull on empty: push kept, pull flagged.
        tx_push = 1'b1; tx_din = 32'h66; tx_pull = 1'b1; step();
        chk("empty_pp_level", 32'(tx_level), 32'd1);
        chk("empty_pp_dout", tx_dout, 32'h66);
        chk("empty_pp_flags", 32'(flags), 32'h2);
        tx_pull = 1'b1; step();
        flag_clr = 4'hF; step();
        chk("clr_all", 32'(flags), 32'h0);

        // TX join: eight entries, RX disabled.
        join_mode = 2'b01; step();
        chk("jtx_level0", 32'(tx_level), 32'd0);
        chk("jtx_rx_empty", 32'(rx_empty), 32'd1);
        chk("jtx_rx_full", 32'(rx_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tx_push = 1'b1; tx_din = 32'h100 + 32'(i); step();
            chk("jtx_level", 32'(tx_level), 32'(i + 1));
            chk("jtx_full", 32'(tx_full), (i == 7) ? 32'd1 : 32'd0);
        end
        rx_push = 1'b1; rx_din = 32'hDEAD; step();
        chk("jtx_rx_push_flag", 32'(flags), 32'h4);
        chk("jtx_irq_rx", 32'(irq_rx), 32'd0);
        chk("jtx_irq_tx", 32'(irq_tx), 32'd0);
        chk("jtx_rx_dout", rx_dout, 32'h0);
        chk("jtx_head0", tx_dout, 32'h100);
        tx_pull = 1'b1; step();
        chk("jtx_head1", tx_dout, 32'h101);
        tx_pull = 1'b1; step();
        chk("jtx_level6", 32'(tx_level), 32'd6);
        join_mode = 2'b00; tx_push = 1'b1; tx_pull = 1'b1; tx_din = 32'hBAD; step();
        chk("unjoin_level", 32'(tx_level), 32'd0);
        chk("unjoin_empty", 32'(tx_empty), 32'd1);
        chk("unjoin_flags", 32'(flags), 32'h4);
        flag_clr = 4'hF; step();

        // RX thresholds.
        rx_push = 1'b1; rx_din = 32'hA1; step();
        chk("rx_irq_1", 32'(irq_rx), 32'd0);
        rx_push = 1'b1; rx_din = 32'hA2; step();
        chk("rx_irq_2", 32'(irq_rx), 32'd0);
        rx_push = 1'b1; rx_din = 32'hA3; step();
        chk("rx_irq_3", 32'(irq_rx), 32'd1);
        chk("rx_level_3", 32'(rx_level), 32'd3);
        chk("rx_head_a1", rx_dout, 32'hA1);
        rx_pull = 1'b1; step();
        chk("rx_pull_head", rx_dout, 32'hA2);
        chk("rx_pull_irq", 32'(irq_rx), 32'd0);
        chk("rx_pull_level", 32'(rx_level), 32'd2);
        rx_thresh = 4'd0;
        rx_push = 1'b1; rx_din = 32'hA4; tx_push = 1'b1; tx_din = 32'h77; step();
        rx_push = 1'b1; rx_din = 32'hA5; step();
        chk("rx_full_level", 32'(rx_level), 32'd4);
        chk("rx_full", 32'(rx_full), 32'd1);
        chk("rx_thresh0_irq", 32'(irq_rx), 32'd0);
        chk("tx_isolated_dout", tx_dout, 32'h77);
        chk("tx_isolated_level", 32'(tx_level), 32'd1);
        rx_push = 1'b1; rx_din = 32'hA6; step();
        chk("rx_ovf_flag", 32'(flags), 32'h4);
        chk("rx_ovf_level", 32'(rx_level), 32'd4);
        exp_rx = '{32'hA2, 32'hA3, 32'hA4, 32'hA5};
        for (int i = 0; i < 4; i++) begin
            chk("rx_drain_head", rx_dout, exp_rx[i]);
            rx_pull = 1'b1; step();
        end
        rx_pull = 1'b1; step();
        chk("rx_udf_flag", 32'(flags), 32'hC);
        chk("rx_udf_dout", rx_dout, 32'h0);

        chk("tx_77_head", tx_dout, 32'h77);
        tx_pull = 1'b1; step();
        chk("tx_77_empty", 32'(tx_empty), 32'd1);

        // Flush discards contents and concurrent push, leaves flags alone.
        tx_push = 1'b1; tx_din = 32'h300; step();
        tx_push = 1'b1; tx_din = 32'h301; flush = 1'b1; step();
        chk("flush_level", 32'(tx_level), 32'd0);
        chk("flush_flags", 32'(flags), 32'hC);

        // Pointer wrap with level kept between 1 and 3.
        tx_push = 1'b1; tx_din = 32'h200; step();
        tx_push = 1'b1; tx_din = 32'h201; step();
        q = '{32'h200, 32'h201};
        nxt = 32'h202;
        for (int i = 0; i < 20; i++) begin
            automatic bit do_push = ((i % 4) != 2);
            automatic bit do_pull = ((i % 4) != 1);
            if (do_pull) chk("wrap_head", tx_dout, q[0]);
            tx_push = do_push; tx_din = nxt; tx_pull = do_pull;
            step();
            if (do_pull) void'(q.pop_front());
            if (do_push) begin
                q.push_back(nxt);
                nxt = nxt + 32'h1;
            end
            chk("wrap_level", 32'(tx_level), 32'(q.size()));
        end

        // Reset mid-stream overrides concurrent operations.
        reset = 1'b0;
        tx_push = 1'b1; tx_din = 32'h999; tx_pull = 1'b1; rx_push = 1'b1; rx_din = 32'h888;
        step();
        chk("mid_rst_tx_level", 32'(tx_level), 32'd0);
        chk("mid_rst_tx_empty", 32'(tx_empty), 32'd1);
        chk("mid_rst_tx_dout", tx_dout, 32'h0);
        chk("mid_rst_rx_level", 32'(rx_level), 32'd0);
        chk("mid_rst_flags", 32'(flags), 32'h0);
        chk("mid_rst_irq_tx", 32'(irq_tx), 32'd1);
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
